// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: takes fade commands and moves each channel's duty 1 LSB at a time toward its target.
// A free-running millisecond tick sets the pace of every ramp.
module pwm_fade_scheduler #(
  parameter int SYS_FREQ = 125,
  parameter int N = 7,
  parameter int CH = 3
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_ch,
  input  logic [N-1:0]    cmd_target,
  input  logic [7:0]      cmd_step_ms,
  output logic [CH*N-1:0] duty_out,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   done,
  output logic            cmd_err,
  output logic            tick_ms
);
  localparam logic [26:0] PRE_MAX = 27'(SYS_FREQ * 1000 - 1);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [26:0] pre_q, pre_d;
  logic tick_q, tick_d;
  logic [1:0] ch_q, ch_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic [7:0] step_q, step_d;
  logic err_q, err_d;
  logic [N-1:0] duty_q [CH];
  logic [N-1:0] duty_d [CH];
  logic [N-1:0] target_q [CH];
  logic [N-1:0] target_d [CH];
  logic [7:0] intv_q [CH];
  logic [7:0] intv_d [CH];
  logic [7:0] cnt_q [CH];
  logic [7:0] cnt_d [CH];
  logic [CH-1:0] busy_q, busy_d, done_q, done_d;
  logic ch_ok, imm;
  assign ch_ok = {1'b0, ch_q} < 3'(CH);
  assign cmd_ready = (state_q == IDLE);
  assign busy = busy_q;
  assign done = done_q;
  assign cmd_err = err_q;
  assign tick_ms = tick_q;
  for (genvar g = 0; g < CH; g++) begin : g_out
    assign duty_out[g*N +: N] = duty_q[g];
  end
  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 27'd1;
    tick_d = (pre_q == PRE_MAX);
    state_d = state_q;
    ch_d = ch_q;
    tgt_d = tgt_q;
    step_d = step_q;
    err_d = 1'b0;
    imm = 1'b0;
    if (state_q == IDLE && cmd_valid) begin
      state_d = LOAD;
      ch_d = cmd_ch;
      tgt_d = cmd_target;
      step_d = cmd_step_ms;
    end
    if (state_q == LOAD) begin
      state_d = IDLE;
      err_d = !ch_ok;
    end
    for (int k = 0; k < CH; k++) begin
      duty_d[k] = duty_q[k];
      target_d[k] = target_q[k];
      intv_d[k] = intv_q[k];
      cnt_d[k] = cnt_q[k];
      busy_d[k] = busy_q[k];
      done_d[k] = 1'b0;
      // A load on this channel overrides any step the same tick would cause
      if (state_q == LOAD && ch_ok && ch_q == 2'(k)) begin
        imm = (step_q == 8'd0) || (tgt_q == duty_q[k]);
        target_d[k] = tgt_q;
        intv_d[k] = step_q;
        cnt_d[k] = '0;
        duty_d[k] = imm ? tgt_q : duty_q[k];
        busy_d[k] = !imm;
        done_d[k] = imm;
      end else if (tick_q && busy_q[k]) begin
        if (cnt_q[k] == intv_q[k] - 8'd1) begin
          cnt_d[k] = '0;
          duty_d[k] = (duty_q[k] < target_q[k]) ? duty_q[k] + 1'b1 :
                      (duty_q[k] > target_q[k]) ? duty_q[k] - 1'b1 : duty_q[k];
          busy_d[k] = (duty_d[k] != target_q[k]);
          done_d[k] = (duty_d[k] == target_q[k]);
        end else begin
          cnt_d[k] = cnt_q[k] + 8'd1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      pre_q <= '0;
      tick_q <= 1'b0;
      ch_q <= '0;
      tgt_q <= '0;
      step_q <= '0;
      err_q <= 1'b0;
      duty_q <= '{default: '0};
      target_q <= '{default: '0};
      intv_q <= '{default: '0};
      cnt_q <= '{default: '0};
      busy_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      tick_q <= tick_d;
      ch_q <= ch_d;
      tgt_q <= tgt_d;
      step_q <= step_d;
      err_q <= err_d;
      duty_q <= duty_d;
      target_q <= target_d;
      intv_q <= intv_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
